// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Four-master round-robin bus arbiter with registered one-hot grant
//            and a combinational slave-side mux of the owning master.
//            Optional grant-hold timeout enabled by macro BUS_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int BUS_ADD_WIDTH  = 30,
  parameter int BUS_DAT_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [3:0]                 m_req_i,
  output logic [3:0]                 m_grnt_o,
  input  logic [4*BUS_ADD_WIDTH-1:0] m_addr_i,
  input  logic [3:0]                 m_as_i,
  input  logic [3:0]                 m_rw_i,
  input  logic [4*BUS_DAT_WIDTH-1:0] m_wr_data_i,
  output logic [BUS_DAT_WIDTH-1:0]   m_rd_data_o,
  output logic [3:0]                 m_rdy_o,
  output logic [BUS_ADD_WIDTH-1:0]   bus_addr_o,
  output logic                       bus_as_o,
  output logic                       bus_rw_o,
  output logic [BUS_DAT_WIDTH-1:0]   bus_wr_data_o,
  input  logic [BUS_DAT_WIDTH-1:0]   bus_rd_data_i,
  input  logic                       bus_rdy_i,
  output logic                       arb_timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] owner;
  logic [1:0] rr_ptr;
  logic [3:0] grnt_q;

  // Unpacked views of the packed master buses, one entry per master.
  logic [BUS_ADD_WIDTH-1:0] addr_arr [4];
  logic [BUS_DAT_WIDTH-1:0] wdat_arr [4];

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign addr_arr[g] = m_addr_i[g*BUS_ADD_WIDTH +: BUS_ADD_WIDTH];
    assign wdat_arr[g] = m_wr_data_i[g*BUS_DAT_WIDTH +: BUS_DAT_WIDTH];
  end

  // One-hot encoding of a master index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // First set request at or above 'start' (mod 4); result is {found, index}.
  // Scanning from the far end down lets the nearest candidate win.
  function automatic logic [2:0] find_first(input logic [3:0] req,
                                            input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick_idle;
  logic [2:0] pick_rel;
  logic       hold_expired;

  // From IDLE the search starts at the round-robin pointer; on release it
  // starts just past the owner, and the owner itself is masked out so a
  // re-raised request cannot jump ahead of the others.
  assign pick_idle = find_first(m_req_i, rr_ptr);
  assign pick_rel  = find_first(m_req_i & ~onehot(owner), owner + 2'd1);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign hold_expired  = (state == ST_OWN) &&
                         (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign arb_timeout_o = timeout_q;
`else
  assign hold_expired  = 1'b0;
  assign arb_timeout_o = 1'b0;
`endif

  // Arbitration state machine: owner tracking, grant register, pointer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      owner     <= 2'd0;
      rr_ptr    <= 2'd0;
      grnt_q    <= 4'b0000;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_idle[2]) begin
            state  <= ST_OWN;
            owner  <= pick_idle[1:0];
            grnt_q <= onehot(pick_idle[1:0]);
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        ST_OWN: begin
          if (m_req_i[owner] && !hold_expired) begin
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end else begin
            rr_ptr <= owner + 2'd1;
`ifdef BUS_ARB_TIMEOUT_EN
            timeout_q <= hold_expired;
            hold_cnt  <= '0;
`endif
            if (pick_rel[2]) begin
              owner  <= pick_rel[1:0];
              grnt_q <= onehot(pick_rel[1:0]);
            end else begin
              state  <= ST_IDLE;
              grnt_q <= 4'b0000;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          grnt_q <= 4'b0000;
        end
      endcase
    end
  end

  assign m_grnt_o    = grnt_q;
  assign m_rd_data_o = bus_rd_data_i;
  assign m_rdy_o     = {4{bus_rdy_i}} & grnt_q;

  // Slave-side mux of the owner's signals; parked values while idle.
  always_comb begin
    bus_addr_o    = '0;
    bus_as_o      = 1'b0;
    bus_rw_o      = 1'b1;
    bus_wr_data_o = '0;
    if (state == ST_OWN) begin
      bus_addr_o    = addr_arr[owner];
      bus_as_o      = m_as_i[owner];
      bus_rw_o      = m_rw_i[owner];
      bus_wr_data_o = wdat_arr[owner];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Self-checking bench for bus_arbiter: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0]      grnt;
  logic [4*AW-1:0] addr;
  logic [3:0]      as_v;
  logic [3:0]      rw_v;
  logic [4*DW-1:0] wdat;
  logic [DW-1:0]   m_rdat;
  logic [3:0]      m_rdy;
  logic [AW-1:0]   b_addr;
  logic            b_as;
  logic            b_rw;
  logic [DW-1:0]   b_wdat;
  logic [DW-1:0]   b_rdat;
  logic            b_rdy;
  logic            tmo;

  always #5 clk = ~clk;

  bus_arbiter #(
    .BUS_ADD_WIDTH (AW),
    .BUS_DAT_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .m_req_i      (req),
    .m_grnt_o     (grnt),
    .m_addr_i     (addr),
    .m_as_i       (as_v),
    .m_rw_i       (rw_v),
    .m_wr_data_i  (wdat),
    .m_rd_data_o  (m_rdat),
    .m_rdy_o      (m_rdy),
    .bus_addr_o   (b_addr),
    .bus_as_o     (b_as),
    .bus_rw_o     (b_rw),
    .bus_wr_data_o(b_wdat),
    .bus_rd_data_i(b_rdat),
    .bus_rdy_i    (b_rdy),
    .arb_timeout_o(tmo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner as an integer (-1 = nobody), pointer, hold age.
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_tmo;

  typedef struct {
    logic [3:0] req;
    logic [3:0] grnt;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_tmo   = 1'b0;
  endtask

  // One clock edge of the arbitration rules, applied to the current inputs.
  task automatic model_step();
    bit expired;
    int prev;
    expired = TMO_EN && (m_owner >= 0) && (m_cnt == TO - 1);
    m_tmo   = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (req[(m_ptr + i) % 4]) begin
          m_owner = (m_ptr + i) % 4;
          m_cnt   = 0;
          break;
        end
      end
    end else if (req[m_owner] && !expired) begin
      m_cnt++;
    end else begin
      prev    = m_owner;
      m_ptr   = (prev + 1) % 4;
      m_tmo   = expired;
      m_owner = -1;
      m_cnt   = 0;
      for (int i = 1; i < 4; i++) begin
        if (req[(prev + i) % 4]) begin
          m_owner = (prev + i) % 4;
          break;
        end
      end
    end
  endtask

  // Compare every DUT output with what the model predicts.
  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    check({tag, " grnt"}, 64'(grnt), 64'(eg));
    check({tag, " rdy"}, 64'(m_rdy), 64'(eg & {4{b_rdy}}));
    check({tag, " rdat"}, 64'(m_rdat), 64'(b_rdat));
    check({tag, " tmo"}, 64'(tmo), 64'(m_tmo));
    if (m_owner < 0) begin
      check({tag, " idle addr"}, 64'(b_addr), 64'd0);
      check({tag, " idle as"}, 64'(b_as), 64'd0);
      check({tag, " idle rw"}, 64'(b_rw), 64'd1);
      check({tag, " idle wdat"}, 64'(b_wdat), 64'd0);
    end else begin
      check({tag, " addr"}, 64'(b_addr), 64'(addr[m_owner*AW +: AW]));
      check({tag, " as"}, 64'(b_as), 64'(as_v[m_owner]));
      check({tag, " rw"}, 64'(b_rw), 64'(rw_v[m_owner]));
      check({tag, " wdat"}, 64'(b_wdat), 64'(wdat[m_owner*DW +: DW]));
    end
  endtask

  // Advance one clock; returns one time unit after the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_fixed_buses();
    for (int n = 0; n < 4; n++) begin
      addr[n*AW +: AW] = AW'(32'h0100_0000 + n * 32'h111);
      wdat[n*DW +: DW] = 32'hA5A5_0000 + 32'(n);
    end
    as_v = 4'b1111;
    rw_v = 4'b0101;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    b_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_model("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [5];

    rst_n  = 1'b0;
    req    = 4'b0000;
    b_rdy  = 1'b0;
    b_rdat = '0;
    set_fixed_buses();
    model_reset();

    tbl[0]  = '{4'b0001, 4'b0001};
    tbl[1]  = '{4'b0011, 4'b0001};
    tbl[2]  = '{4'b0010, 4'b0010};
    tbl[3]  = '{4'b0000, 4'b0000};
    tbl[4]  = '{4'b0111, 4'b0100};
    tbl[5]  = '{4'b0011, 4'b0001};
    tbl[6]  = '{4'b0001, 4'b0001};
    tbl[7]  = '{4'b1001, 4'b0001};
    tbl[8]  = '{4'b1000, 4'b1000};
    tbl[9]  = '{4'b0000, 4'b0000};
    tbl[10] = '{4'b1111, 4'b0001};

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("tbl[%0d] grnt", i), 64'(grnt), 64'(tbl[i].grnt));
      check_model($sformatf("tbl[%0d]", i));
    end

    // Rotation with every master requesting and each dropping after its grant.
    do_reset();
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0001;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rot[%0d] grnt", i), 64'(grnt), 64'(seq[i]));
      req = 4'b1111 & ~grnt;
    end

    // Owner 1 sees the slave ready; read data reaches every master.
    do_reset();
    req    = 4'b0010;
    b_rdy  = 1'b1;
    b_rdat = 32'hDEAD_BEEF;
    step();
    check("own1 grnt", 64'(grnt), 64'h2);
    check("own1 rdy", 64'(m_rdy), 64'h2);
    check("own1 rdat", 64'(m_rdat), 64'hDEAD_BEEF);
    check("own1 addr", 64'(b_addr), 64'(AW'(32'h0100_0111)));
    check("own1 as", 64'(b_as), 64'd1);

    // Asynchronous reset in the middle of a cycle with the strobe active.
    #2;
    rst_n = 1'b0;
    #1;
    check("async grnt", 64'(grnt), 64'h0);
    check("async as", 64'(b_as), 64'd0);
    check("async rw", 64'(b_rw), 64'd1);
    check("async addr", 64'(b_addr), 64'd0);
    model_reset();
    req   = 4'b0000;
    b_rdy = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Master 0 holds its request while master 2 waits.
    do_reset();
    req = 4'b0101;
    step();
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("hold[%0d] grnt", k), 64'(grnt), 64'h1);
      check($sformatf("hold[%0d] tmo", k), 64'(tmo), 64'd0);
      step();
    end
    check("revoke grnt", 64'(grnt), 64'h4);
    check("revoke tmo", 64'(tmo), 64'd1);
    step();
    check("after revoke grnt", 64'(grnt), 64'h4);
    check("after revoke tmo", 64'(tmo), 64'd0);
`else
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("hold[%0d] grnt", k), 64'(grnt), 64'h1);
      check($sformatf("hold[%0d] tmo", k), 64'(tmo), 64'd0);
      step();
    end
`endif

    // Randomized traffic: requests toggle occasionally so grants get held.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 3) == 0) req[n] = ~req[n];
        addr[n*AW +: AW] = AW'($urandom);
        wdat[n*DW +: DW] = $urandom;
      end
      as_v   = 4'($urandom);
      rw_v   = 4'($urandom);
      b_rdy  = 1'($urandom);
      b_rdat = $urandom;
      #1;
      check_model("rand comb");
      step();
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_ADD_WIDTH, default 30, word address width of every master and slave port.
REQ-002 Parameter BUS_DAT_WIDTH, default 32, data width of every master and slave port.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, maximum grant hold in cycles; used only with BUS_ARB_TIMEOUT_EN.
REQ-004 clk_i  input  1  single system clock; all state changes on the rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-006 m_req_i  input  4  per-master bus request; bit n is master n (0 = IF stage, 1 = MEM stage, 2..3 = spare).
REQ-007 m_grnt_o  output  4  one-hot-or-zero grant to masters, registered.
REQ-008 m_addr_i  input  4*BUS_ADD_WIDTH  packed master addresses, master n at slice n.
REQ-009 m_as_i  input  4  per-master address strobe.
REQ-010 m_rw_i  input  4  per-master direction, 1 = read, 0 = write.
REQ-011 m_wr_data_i  input  4*BUS_DAT_WIDTH  packed master write data.
REQ-012 m_rd_data_o  output  BUS_DAT_WIDTH  read data broadcast to all masters.
REQ-013 m_rdy_o  output  4  per-master ready.
REQ-014 bus_addr_o  output  BUS_ADD_WIDTH  slave-side address.
REQ-015 bus_as_o  output  1  slave-side address strobe.
REQ-016 bus_rw_o  output  1  slave-side direction.
REQ-017 bus_wr_data_o  output  BUS_DAT_WIDTH  slave-side write data.
REQ-018 bus_rd_data_i  input  BUS_DAT_WIDTH  slave read data.
REQ-019 bus_rdy_i  input  1  slave ready.
REQ-020 arb_timeout_o  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-021 States: IDLE (m_grnt_o = 0) and OWN (exactly one grant bit set); owner index held in a 2-bit register.
REQ-022 IDLE: any m_req_i bit set -> OWN next edge, granting the first requester found searching upward (mod 4) from the round-robin pointer; latency request-to-grant is one cycle.
REQ-023 OWN: grant held unchanged while m_req_i[owner] = 1, regardless of other requests.
REQ-024 OWN with m_req_i[owner] = 0: at the next edge, grant moves to the first requester searching from owner+1 (mod 4), excluding owner; if none, -> IDLE.
REQ-025 The round-robin pointer updates to owner+1 (mod 4) whenever a grant is released.
REQ-026 A master whose request drops and re-rises in the same release cycle is not re-granted ahead of other pending requesters.
REQ-027 Slave-side outputs are a combinational mux of the owner's addr, rw and wr_data; bus_as_o = m_as_i[owner] AND OWN.
REQ-028 In IDLE: bus_addr_o = 0, bus_as_o = 0, bus_rw_o = 1, bus_wr_data_o = 0.
REQ-029 m_rd_data_o = bus_rd_data_i unconditionally; m_rdy_o[n] = bus_rdy_i AND m_grnt_o[n].
REQ-030 No combinational path from m_req_i to m_grnt_o.

Reset
REQ-031 rst_n_i low forces, asynchronously: state IDLE, m_grnt_o = 0, pointer = 0, timeout counter = 0, arb_timeout_o = 0.
REQ-032 Reset asserted mid-transfer drops the grant immediately, and the slave-side outputs take their IDLE values.
REQ-033 After reset release, the first arbitration starts from master 0.

Configuration
REQ-034 Macro BUS_ARB_TIMEOUT_EN defined: a counter clears on each new grant and increments each OWN cycle.
REQ-035 When the counter reaches TIMEOUT_CYCLES-1, the grant is revoked at the next edge and passed per REQ-024 with the owner treated as not requesting, and arb_timeout_o pulses high for that one cycle.
REQ-036 Macro BUS_ARB_TIMEOUT_EN not defined: no counter is built, arb_timeout_o is tied 0, and grants are held indefinitely.

Verification
REQ-037 Reset, then m_req_i=4'b0001 -> m_grnt_o=4'b0001 one cycle later; bus_addr_o equals m_addr_i slice 0.
REQ-038 m_req_i=4'b0011 from IDLE after reset -> grant 4'b0001; drop bit 0 -> grant 4'b0010 next edge with no IDLE cycle.
REQ-039 All four requesting continuously, each dropping req one cycle after its grant -> grant sequence 0001,0010,0100,1000,0001.
REQ-040 Owner 1 with bus_rdy_i=1 -> m_rdy_o=4'b0010, and m_rd_data_o=bus_rd_data_i on all masters.
REQ-041 Assert rst_n_i low mid-grant with bus_as_o=1 -> m_grnt_o=0 and bus_as_o=0 without waiting for a clock edge.
REQ-042 With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, and master 0 holding req while master 2 requests -> after 8 OWN cycles arb_timeout_o pulses once and the grant moves to 4'b0100.
